// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input and instruction-memory write bus of the encoder/loader.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the field side, im_we/im_ready on the IM side.
//
// Ports (slave = loader view):
//   in_valid, in_type[3:0], in_rs/in_rt/in_rd[4:0], in_imm[25:0]  -> loader
//   in_ready                                                      <- loader
//   im_we, im_addr[31:0], im_wdata[31:0]                          <- loader
//   im_ready                                                      -> loader
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_type;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        im_ready;

  modport slave (
    input  in_valid, in_type, in_rs, in_rt, in_rd, in_imm, im_ready,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output in_valid, in_type, in_rs, in_rt, in_rd, in_imm, im_ready,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instructions into 32-bit words and writes them to IM.
// Latency: bundle accepted at edge N appears on im_* in cycle N+1 (FIFO empty).
// Backpressure: im_ready low fills the 4-word FIFO, then in_ready drops.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low
//   start  - 1-cycle pulse: flush FIFO, rewind address/count, clear err, enter LOAD
//   bus    - field handshake in, IM write port out (see instr_encoder_loader_if)
//   count  - words written to IM since start
//   err    - sticky: an illegal type code (14/15) was accepted
//   done   - IM capacity reached (FULL state)
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  instr_encoder_loader_if.slave   bus,
  output logic [12:0]             count,
  output logic                    err,
  output logic                    done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL} state_e;

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [13:0]    CAP     = 14'(IM_WORDS);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  state_e         state_q, state_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]    mem_q [FIFO_DEPTH];
  logic [31:0]    mem_d [FIFO_DEPTH];
  logic [31:0]    addr_q, addr_d;
  logic [12:0]    count_q, count_d;
  logic           err_q, err_d;

  logic [PTR_W:0] occ;
  logic           fifo_empty, fifo_full, room, in_rdy, accept, pop;
  logic [31:0]    enc_word;
  logic           enc_legal;

  // Encoder: only the fields an instruction format uses reach the word.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (bus.in_type)
      4'd0:  enc_word = 32'h0000_0000;
      4'd1:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
      4'd2:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
      4'd3:  enc_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd4:  enc_word = {6'h0F, 5'd0, bus.in_rt, bus.in_imm[15:0]};
      4'd5:  enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd6:  enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd7:  enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd8:  enc_word = {6'h03, bus.in_imm};
      4'd9:  enc_word = {6'h00, bus.in_rs, 15'd0, 6'h08};
      4'd10: enc_word = 32'h0000_000C;
      4'd11: enc_word = {6'h10, 5'd0, bus.in_rt, bus.in_rd, 11'd0};
      4'd12: enc_word = {6'h10, 5'd4, bus.in_rt, bus.in_rd, 11'd0};
      4'd13: enc_word = 32'h4200_0018;
      default: enc_legal = 1'b0;
    endcase
  end

  assign occ        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == DEPTH_L);
  // Words already buffered count against capacity so FULL is reached with an empty FIFO.
  assign room       = (14'(count_q) + 14'(occ)) < CAP;
  assign in_rdy     = (state_q == ST_LOAD) && !fifo_full && room;
  assign accept     = bus.in_valid && in_rdy;
  assign pop        = !fifo_empty && bus.im_ready;

  assign bus.in_ready = in_rdy;
  assign bus.im_we    = !fifo_empty;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = fifo_empty ? 32'h0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign count        = count_q;
  assign err          = err_q;
  assign done         = (state_q == ST_FULL);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (start) begin
      // Restart wins over everything: buffered words and a same-cycle accept are dropped.
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      addr_d   = BASE_ADDR;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (accept && enc_legal) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = enc_word;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (accept && !enc_legal) begin
        err_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        addr_d   = addr_q + 32'd4;
        count_d  = count_q + 13'd1;
      end
      if ((state_q == ST_LOAD) && (14'(count_q) == CAP)) begin
        state_d = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE_ADDR;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: default instance plus an 8-word instance for capacity.
// Latency: stimulus driven and outputs sampled on the falling edge.
// Backpressure: im_ready driven per scenario; every wait is cycle-bounded.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_type = 4'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [25:0] in_imm = 26'd0;
  logic        im_ready = 1'b0;
  logic        im_ready8 = 1'b0;

  logic [12:0] count, count8;
  logic        err, err8, done, done8;

  int total = 0;
  int bad = 0;

  logic [31:0] la[$], ld[$], la8[$], ld8[$];

  always #5 clk = ~clk;

  instr_encoder_loader_if bus();
  instr_encoder_loader_if b8();

  assign bus.in_valid = in_valid;
  assign bus.in_type  = in_type;
  assign bus.in_rs    = in_rs;
  assign bus.in_rt    = in_rt;
  assign bus.in_rd    = in_rd;
  assign bus.in_imm   = in_imm;
  assign bus.im_ready = im_ready;
  assign b8.in_valid  = in_valid;
  assign b8.in_type   = in_type;
  assign b8.in_rs     = in_rs;
  assign b8.in_rt     = in_rt;
  assign b8.in_rd     = in_rd;
  assign b8.in_imm    = in_imm;
  assign b8.im_ready  = im_ready8;

  instr_encoder_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .count(count), .err(err), .done(done)
  );

  instr_encoder_loader #(.IM_WORDS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .bus(b8),
    .count(count8), .err(err8), .done(done8)
  );

  always @(posedge clk) begin
    if (reset && bus.im_we && bus.im_ready) begin
      la.push_back(bus.im_addr);
      ld.push_back(bus.im_wdata);
    end
    if (reset && b8.im_we && b8.im_ready) begin
      la8.push_back(b8.im_addr);
      ld8.push_back(b8.im_wdata);
    end
  end

  task automatic pulse_start(input logic sel);
    @(negedge clk);
    if (sel) start8 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send(input logic sel, input logic [3:0] t, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [25:0] imm,
                      input int budget, input logic must, output logic ok);
    int n;
    in_type = t; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (n < budget) begin
      if (sel ? b8.in_ready : bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
    if (must && !ok) begin
      total++; bad++;
      $display("FAIL send_timeout type=%0d: in_ready stayed 0 for %0d cycles, required 1", t, budget);
    end
  endtask

  task automatic wait_writes(input logic sel, input int target, input int budget);
    int n;
    n = 0;
    while (((sel ? la8.size() : la.size()) < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? la8.size() : la.size()) < target) begin
      total++; bad++;
      $display("FAIL write_timeout: got %0d writes, required %0d", sel ? la8.size() : la.size(), target);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total += 8;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    if (bus.im_we !== 1'b0) begin bad++; $display("FAIL rst_im_we got=%b exp=0", bus.im_we); end
    if (bus.im_addr !== 32'h0000_3000) begin bad++; $display("FAIL rst_im_addr got=%h exp=00003000", bus.im_addr); end
    if (bus.im_wdata !== 32'h0) begin bad++; $display("FAIL rst_im_wdata got=%h exp=0", bus.im_wdata); end
    if (count !== 13'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    if (done8 !== 1'b0) begin bad++; $display("FAIL rst_done8 got=%b exp=0", done8); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b exp=0", bus.in_ready); end
  endtask

  task automatic test_single;
    logic ok;
    pulse_start(1'b0);
    la.delete(); ld.delete();
    im_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL load_in_ready got=%b exp=1", bus.in_ready); end
    send(1'b0, 4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 20, 1'b1, ok);
    total += 4;
    if (bus.im_we !== 1'b1) begin bad++; $display("FAIL t1_im_we got=%b exp=1", bus.im_we); end
    if (bus.im_addr !== 32'h0000_3000) begin bad++; $display("FAIL t1_addr got=%h exp=00003000", bus.im_addr); end
    if (bus.im_wdata !== 32'h0022_1820) begin bad++; $display("FAIL t1_wdata got=%h exp=00221820", bus.im_wdata); end
    if (count !== 13'd0) begin bad++; $display("FAIL t1_count_pre got=%0d exp=0", count); end
    im_ready = 1'b1;
    @(negedge clk);
    im_ready = 1'b0;
    total += 4;
    if (count !== 13'd1) begin bad++; $display("FAIL t1_count got=%0d exp=1", count); end
    if (bus.im_we !== 1'b0) begin bad++; $display("FAIL t1_we_after got=%b exp=0", bus.im_we); end
    if (bus.im_addr !== 32'h0000_3004) begin bad++; $display("FAIL t1_addr_after got=%h exp=00003004", bus.im_addr); end
    if (ld.size() !== 1 || ld[0] !== 32'h0022_1820) begin
      bad++; $display("FAIL t1_log got=%0d writes exp=1 of 00221820", ld.size());
    end
  endtask

  task automatic test_stream;
    logic [3:0]  vt [13] = '{4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd13, 4'd2, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0};
    logic [4:0]  vs [13] = '{5'd0, 5'd7, 5'd5, 5'd1, 5'd3, 5'd31, 5'd4, 5'd29, 5'd31, 5'd1, 5'd9, 5'd9, 5'd31};
    logic [4:0]  vr [13] = '{5'd1, 5'd2, 5'd4, 5'd2, 5'd3, 5'd31, 5'd5, 5'd31, 5'd5, 5'd1, 5'd8, 5'd8, 5'd31};
    logic [4:0]  vd [13] = '{5'd0, 5'd9, 5'd0, 5'd0, 5'd3, 5'd31, 5'd6, 5'd7, 5'd5, 5'd1, 5'd12, 5'd12, 5'd31};
    logic [25:0] vi [13] = '{26'h3FF1234, 26'h000ABCD, 26'h0000008, 26'h000FFFF, 26'h0000C00, 26'h3FFFFFF,
                             26'h3FFFFFF, 26'h3FF0004, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF};
    logic [31:0] ew [13] = '{32'h3401_1234, 32'h3C02_ABCD, 32'h8CA4_0008, 32'h1022_FFFF, 32'h0C00_0C00,
                             32'h4200_0018, 32'h0085_3022, 32'hAFBF_0004, 32'h03E0_0008, 32'h0000_000C,
                             32'h4008_6000, 32'h4088_6000, 32'h0000_0000};
    logic ok;
    pulse_start(1'b0);
    la.delete(); ld.delete();
    im_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(1'b0, vt[i], vs[i], vr[i], vd[i], vi[i], 5, 1'b1, ok);
    end
    wait_writes(1'b0, 13, 20);
    for (int i = 0; i < 13; i++) begin
      total++;
      if (i >= ld.size() || ld[i] !== ew[i] || la[i] !== 32'h0000_3000 + 32'(4 * i)) begin
        bad++;
        $display("FAIL stream_word%0d got addr=%h data=%h exp addr=%h data=%h", i,
                 (i < la.size()) ? la[i] : 32'hx, (i < ld.size()) ? ld[i] : 32'hx,
                 32'h0000_3000 + 32'(4 * i), ew[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ew [4] = '{32'h0022_1820, 32'h0043_2020, 32'h0064_2820, 32'h0085_3020};
    int acc;
    logic held_bad;
    pulse_start(1'b0);
    la.delete(); ld.delete();
    im_ready = 1'b0;
    acc = 0;
    held_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c >= 1 && (bus.im_we !== 1'b1 || bus.im_addr !== 32'h0000_3000 || bus.im_wdata !== ew[0]))
        held_bad = 1'b1;
      in_type = 4'd1;
      in_rs = 5'(acc + 1); in_rt = 5'(acc + 2); in_rd = 5'(acc + 3);
      in_valid = 1'b1;
      if (bus.in_ready === 1'b1) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total += 5;
    if (acc !== 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    if (held_bad !== 1'b0) begin bad++; $display("FAIL bp_stable got=unstable exp=held at 00003000/%h", ew[0]); end
    if (la.size() !== 0) begin bad++; $display("FAIL bp_no_write got=%0d exp=0", la.size()); end
    if (count !== 13'd0) begin bad++; $display("FAIL bp_count got=%0d exp=0", count); end
    im_ready = 1'b1;
    wait_writes(1'b0, 4, 10);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= ld.size() || ld[i] !== ew[i] || la[i] !== 32'h0000_3000 + 32'(4 * i)) begin
        bad++;
        $display("FAIL bp_word%0d got data=%h exp=%h", i, (i < ld.size()) ? ld[i] : 32'hx, ew[i]);
      end
    end
  endtask

  task automatic test_capacity;
    int n_ok;
    logic ok;
    pulse_start(1'b1);
    la8.delete(); ld8.delete();
    im_ready8 = 1'b1;
    n_ok = 0;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 4'd1, 5'(i), 5'(i), 5'(i), 26'd0, 12, 1'b0, ok);
      if (ok) n_ok++;
    end
    wait_writes(1'b1, 8, 10);
    repeat (3) @(negedge clk);
    total += 8;
    if (n_ok !== 8) begin bad++; $display("FAIL cap_accepted got=%0d exp=8", n_ok); end
    if (la8.size() !== 8) begin bad++; $display("FAIL cap_writes got=%0d exp=8", la8.size()); end
    if (la8.size() != 8 || la8[7] !== 32'h0000_301C || ld8[0] !== 32'h0000_0020 || ld8[7] !== 32'h00E7_3820) begin
      bad++; $display("FAIL cap_last got=%0d writes exp last addr 0000301C data 00E73820", la8.size());
    end
    if (done8 !== 1'b1) begin bad++; $display("FAIL cap_done got=%b exp=1", done8); end
    if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL cap_in_ready got=%b exp=0", b8.in_ready); end
    if (count8 !== 13'd8) begin bad++; $display("FAIL cap_count got=%0d exp=8", count8); end
    if (b8.im_we !== 1'b0) begin bad++; $display("FAIL cap_im_we got=%b exp=0", b8.im_we); end
    if (err8 !== 1'b0) begin bad++; $display("FAIL cap_err got=%b exp=0", err8); end
    im_ready8 = 1'b0;
  endtask

  task automatic test_illegal;
    logic ok;
    pulse_start(1'b0);
    la.delete(); ld.delete();
    im_ready = 1'b1;
    send(1'b0, 4'd14, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF, 5, 1'b1, ok);
    repeat (3) @(negedge clk);
    total += 3;
    if (la.size() !== 0) begin bad++; $display("FAIL ill_no_write got=%0d exp=0", la.size()); end
    if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err); end
    if (count !== 13'd0) begin bad++; $display("FAIL ill_count got=%0d exp=0", count); end
    send(1'b0, 4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 5, 1'b1, ok);
    wait_writes(1'b0, 1, 10);
    total += 2;
    if (ld.size() < 1 || ld[0] !== 32'h0022_1820 || la[0] !== 32'h0000_3000) begin
      bad++; $display("FAIL ill_next_word got=%0d writes exp 00221820 at 00003000", ld.size());
    end
    if (err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", err); end
    pulse_start(1'b0);
    total += 2;
    if (err !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b exp=0", err); end
    if (count !== 13'd0) begin bad++; $display("FAIL restart_count got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    im_ready = 1'b0;
    send(1'b0, 4'd1, 5'd1, 5'd1, 5'd1, 26'd0, 5, 1'b1, ok);
    send(1'b0, 4'd1, 5'd2, 5'd2, 5'd2, 26'd0, 5, 1'b1, ok);
    send(1'b0, 4'd1, 5'd3, 5'd3, 5'd3, 26'd0, 5, 1'b1, ok);
    total++;
    if (bus.im_we !== 1'b1) begin bad++; $display("FAIL mid_pre_we got=%b exp=1", bus.im_we); end
    #1 reset = 1'b0;
    #1;
    total += 5;
    if (bus.im_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%b exp=0", bus.im_we); end
    if (bus.im_addr !== 32'h0000_3000) begin bad++; $display("FAIL mid_addr got=%h exp=00003000", bus.im_addr); end
    if (bus.im_wdata !== 32'h0) begin bad++; $display("FAIL mid_wdata got=%h exp=0", bus.im_wdata); end
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
    if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done); end
    la.delete(); ld.delete();
    im_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (la.size() !== 0) begin bad++; $display("FAIL mid_no_write got=%0d exp=0", la.size()); end
    pulse_start(1'b0);
    send(1'b0, 4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 5, 1'b1, ok);
    wait_writes(1'b0, 1, 10);
    total++;
    if (la.size() < 1 || la[0] !== 32'h0000_3000 || ld[0] !== 32'h0085_3020) begin
      bad++; $display("FAIL mid_restart got=%0d writes exp 00853020 at 00003000", la.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_capacity();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
